blk_mem_hs: RTL and testbench

- Parametrised successor to the single-cycle block memory model used behind the cache data array.
- Stores DEPTH blocks of BLK_WIDTH bits and serves one request at a time over a valid/ready request channel and a valid/ready response channel.
- Access latency is configurable, so cache miss, refill and write-back paths can be exercised against realistic memory timing.
- Sits between the cache controller (mem_addr/mem_rd_en/mem_wr_en side) and the bench.

---
 rtl/blk_mem_pkg.sv | 22 ++
 rtl/blk_mem_array.sv | 48 ++++
 rtl/blk_mem_hs.sv | 121 ++++++++++++
 tb/tb_blk_mem_hs.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_mem_pkg.sv
// Shared types and constants for the handshaked block memory.
// No logic of its own; no latency or backpressure behaviour.
// Imported by blk_mem_array and blk_mem_hs.
package blk_mem_pkg;

   localparam int BYTE          = 8;
   localparam int DEF_PA_WIDTH  = 32;
   localparam int DEF_BLK_WIDTH = 512;
   localparam int DEF_DEPTH     = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } blk_mem_state_t;

   // Number of byte-offset address bits inside one block.
   function automatic int calc_off_w(input int blk_width);
      return $clog2(blk_width / BYTE);
   endfunction

endpackage

// File: rtl/blk_mem_array.sv
// Block storage: combinational read of the selected block, write committed at the clock edge.
// Latency: acc_dat shows the post-write block in the same cycle; no backpressure (always ready).
// Byte-enable merge only when BLK_MEM_BYTE_EN is defined, otherwise full-block writes.
module blk_mem_array
   import blk_mem_pkg::*;
#(
   parameter int BLK_WIDTH = DEF_BLK_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int IDX_W     = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      acc_en,
   input  logic                      acc_we,
   input  logic [IDX_W-1:0]          acc_idx,
   input  logic [BLK_WIDTH-1:0]      wr_dat,
`ifdef BLK_MEM_BYTE_EN
   input  logic [BLK_WIDTH/BYTE-1:0] wr_be,
`endif
   output logic [BLK_WIDTH-1:0]      acc_dat
);

   logic [BLK_WIDTH-1:0] mem [DEPTH];
   logic [BLK_WIDTH-1:0] cur_dat;
   logic [BLK_WIDTH-1:0] new_dat;

   assign cur_dat = mem[acc_idx];

   always_comb begin
      new_dat = wr_dat;
`ifdef BLK_MEM_BYTE_EN
      for (int b = 0; b < BLK_WIDTH / BYTE; b++) begin
         if (!wr_be[b]) begin
            new_dat[b*BYTE +: BYTE] = cur_dat[b*BYTE +: BYTE];
         end
      end
`endif
   end

   // A write reports the block as it will read after this edge.
   assign acc_dat = acc_we ? new_dat : cur_dat;

   always_ff @(posedge clk) begin
      if (acc_en && acc_we) begin
         mem[acc_idx] <= new_dat;
      end
   end

endmodule

// File: rtl/blk_mem_hs.sv
// Block memory with valid/ready request and response channels, one request in flight.
// Latency: resp_valid rises LATENCY edges after the accepting edge; response held until resp_ready.
// req_ready low while busy; BLK_MEM_BYTE_EN adds req_be per-byte write enables.
module blk_mem_hs
   import blk_mem_pkg::*;
#(
   parameter int PA_WIDTH  = DEF_PA_WIDTH,
   parameter int BLK_WIDTH = DEF_BLK_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int LATENCY   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [PA_WIDTH-1:0]       req_addr,
   input  logic [BLK_WIDTH-1:0]      req_wdata,
`ifdef BLK_MEM_BYTE_EN
   input  logic [BLK_WIDTH/BYTE-1:0] req_be,
`endif
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [BLK_WIDTH-1:0]      resp_rdata,
   output logic                      resp_err
);

   localparam int OFF_W = calc_off_w(BLK_WIDTH);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   blk_mem_state_t       state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 accept;
   logic                 access;
   logic                 cap_we;
   logic                 cap_oor;
   logic [IDX_W-1:0]     cap_idx;
   logic [BLK_WIDTH-1:0] cap_wdata;
   logic [BLK_WIDTH-1:0] acc_dat;
   logic                 addr_unused;
`ifdef BLK_MEM_BYTE_EN
   logic [BLK_WIDTH/BYTE-1:0] cap_be;
`endif

   assign addr_unused = ^req_addr[OFF_W-1:0];
   assign accept      = (state == IDLE) && req_valid;
   assign access      = (state == WAIT) && (cnt == '0);

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt      <= CNT_W'(LATENCY - 1);
            resp_err <= 1'b0;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            resp_rdata <= cap_oor ? '0 : acc_dat;
            resp_err   <= cap_oor;
         end
      end
   end

   // Request fields are only meaningful once accepted, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         cap_we    <= req_we;
         cap_idx   <= req_addr[OFF_W +: IDX_W];
         cap_oor   <= |(req_addr >> (OFF_W + IDX_W));
         cap_wdata <= req_wdata;
`ifdef BLK_MEM_BYTE_EN
         cap_be    <= req_be;
`endif
      end
   end

   // Reset on the access edge must still suppress the write.
   blk_mem_array #(
      .BLK_WIDTH (BLK_WIDTH),
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk     (clk),
      .acc_en  (access && !cap_oor && !rst),
      .acc_we  (cap_we),
      .acc_idx (cap_idx),
      .wr_dat  (cap_wdata),
`ifdef BLK_MEM_BYTE_EN
      .wr_be   (cap_be),
`endif
      .acc_dat (acc_dat)
   );

endmodule

// File: tb/tb_blk_mem_hs.sv
// Randomised bench for blk_mem_hs against a block-array reference model.
// Byte-enable scenarios are built only when BLK_MEM_BYTE_EN is defined.
module tb_blk_mem_hs;

   localparam int PA  = 32;
   localparam int BW  = 512;
   localparam int DEP = 16;
   localparam int LAT = 3;
   localparam int NB  = BW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [PA-1:0] req_addr = '0;
   logic [BW-1:0] req_wdata = '0;
   logic          resp_ready = 1'b0;
   logic          req_ready;
   logic          resp_valid;
   logic [BW-1:0] resp_rdata;
   logic          resp_err;
`ifdef BLK_MEM_BYTE_EN
   logic [NB-1:0] req_be = '0;
`endif

   int checks = 0;
   int passes = 0;
   logic [BW-1:0] model [DEP];

   always #5 clk = ~clk;

   blk_mem_hs #(.PA_WIDTH(PA), .BLK_WIDTH(BW), .DEPTH(DEP), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef BLK_MEM_BYTE_EN
      .req_be     (req_be),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] b;
      for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
      return b;
   endfunction

   // Memory seen as DEP blocks of NB bytes; addresses past DEP*NB are errors.
   function automatic void model_access(input logic we, input logic [PA-1:0] addr,
                                        input logic [BW-1:0] wd, input logic [NB-1:0] be,
                                        output logic [BW-1:0] exp_d, output logic exp_e);
      int idx;
      if (addr >= PA'(DEP * NB)) begin
         exp_d = '0;
         exp_e = 1'b1;
      end else begin
         idx = int'(addr / NB);
         if (we) begin
            for (int b = 0; b < NB; b++)
               if (be[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
         end
         exp_d = model[idx];
         exp_e = 1'b0;
      end
   endfunction

   // Issues one request starting at a negedge and returns at the negedge after the handshake.
   task automatic do_req(input logic we, input logic [PA-1:0] addr, input logic [BW-1:0] wd,
                         input logic [NB-1:0] be, input int stall,
                         output logic [BW-1:0] rd, output logic er, output int lat,
                         output logic busy_ok, output logic stable_ok, output logic ready_after);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
`ifdef BLK_MEM_BYTE_EN
      req_be = be;
`endif
      busy_ok = req_ready;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = $urandom(); req_wdata = rand_blk();
      lat = 0;
      while (!resp_valid && lat < 50) begin
         if (req_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      rd = resp_rdata;
      er = resp_err;
      stable_ok = 1'b1;
      ready_after = 1'b0;
      if (resp_valid) begin
         if (req_ready !== 1'b0) busy_ok = 1'b0;
         repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
               stable_ok = 1'b0;
         end
         resp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         resp_ready = 1'b0;
         ready_after = req_ready && !resp_valid;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready); else passes++;
         checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); else passes++;
         checks++; if (resp_rdata !== '0) $display("FAIL rst_rdata: got %h expected 0", resp_rdata); else passes++;
         checks++; if (resp_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", resp_err); else passes++;
      end
      rst = 1'b0; req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL rst_no_accept: got ready=%b valid=%b expected ready=1 valid=0", req_ready, resp_valid);
      else passes++;
   endtask

   task automatic test_fill();
      logic [BW-1:0] wd, rd, ed; logic er, ee, bo, so, ra; int lat;
      for (int i = 0; i < DEP; i++) begin
         wd = rand_blk();
         model_access(1'b1, PA'(i * NB + $urandom_range(0, NB - 1)), wd, '1, ed, ee);
         do_req(1'b1, PA'(i * NB + $urandom_range(0, NB - 1)), wd, '1, 0, rd, er, lat, bo, so, ra);
         checks++; if (lat !== LAT) $display("FAIL fill_lat: got %0d expected %0d", lat, LAT); else passes++;
         checks++; if (rd !== ed || er !== ee) $display("FAIL fill_resp: got %h/%b expected %h/%b", rd, er, ed, ee); else passes++;
      end
   endtask

   task automatic test_write_read();
      logic [BW-1:0] aa, rd, ed; logic er, ee, bo, so, ra; int lat;
      aa = {NB{8'hAA}};
      model_access(1'b1, 32'h40, aa, '1, ed, ee);
      do_req(1'b1, 32'h40, aa, '1, 0, rd, er, lat, bo, so, ra);
      checks++; if (lat !== LAT) $display("FAIL wr_lat: got %0d expected %0d", lat, LAT); else passes++;
      checks++; if (rd !== aa || er !== 1'b0) $display("FAIL wr_resp: got %h/%b expected %h/0", rd, er, aa); else passes++;
      do_req(1'b0, 32'h40, '0, '1, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== aa || er !== 1'b0) $display("FAIL rd_40: got %h/%b expected %h/0", rd, er, aa); else passes++;
      do_req(1'b0, 32'h7F, '0, '1, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== aa || er !== 1'b0) $display("FAIL rd_7f: got %h/%b expected %h/0", rd, er, aa); else passes++;
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] rd, ed; logic er, ee, bo, so, ra; int lat;
      model_access(1'b1, 32'h0, '1, '1, ed, ee);
      do_req(1'b1, 32'h0, '1, '1, 0, rd, er, lat, bo, so, ra);
      do_req(1'b0, 32'h0, '0, '1, 5, rd, er, lat, bo, so, ra);
      checks++; if (rd !== {BW{1'b1}}) $display("FAIL bp_data: got %h expected all ones", rd); else passes++;
      checks++; if (so !== 1'b1) $display("FAIL bp_stable: got %b expected 1", so); else passes++;
      checks++; if (bo !== 1'b1) $display("FAIL bp_busy_ready: got %b expected 1", bo); else passes++;
      checks++; if (ra !== 1'b1) $display("FAIL bp_ready_after: got %b expected 1", ra); else passes++;
   endtask

   task automatic test_range();
      logic [BW-1:0] rd, ed; logic er, ee, bo, so, ra; int lat;
      do_req(1'b0, 32'h400, '0, '1, 1, rd, er, lat, bo, so, ra);
      checks++; if (rd !== '0 || er !== 1'b1) $display("FAIL oor_rd: got %h/%b expected 0/1", rd, er); else passes++;
      do_req(1'b1, 32'h8000_0000, rand_blk(), '1, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== '0 || er !== 1'b1) $display("FAIL oor_wr: got %h/%b expected 0/1", rd, er); else passes++;
      checks++; if (lat !== LAT) $display("FAIL oor_lat: got %0d expected %0d", lat, LAT); else passes++;
      model_access(1'b0, 32'h0, '0, '1, ed, ee);
      do_req(1'b0, 32'h0, '0, '1, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== ed || er !== 1'b0) $display("FAIL oor_after: got %h/%b expected %h/0", rd, er, ed); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] rd, ed; logic er, ee, bo, so, ra, rose; int lat;
      for (int k = 1; k <= LAT; k++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = {NB{8'hCC}};
`ifdef BLK_MEM_BYTE_EN
         req_be = '1;
`endif
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         rose = 1'b0;
         repeat (k - 1) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid) rose = 1'b1;
         end
         rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         checks++; if (resp_rdata !== '0 || resp_err !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL mid_rst_state: got %h/%b/%b expected 0/0/1", resp_rdata, resp_err, req_ready);
         else passes++;
         repeat (LAT + 1) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid) rose = 1'b1;
         end
         checks++; if (rose !== 1'b0) $display("FAIL mid_rst_valid k=%0d: got %b expected 0", k, rose); else passes++;
         model_access(1'b0, 32'h80, '0, '1, ed, ee);
         do_req(1'b0, 32'h80, '0, '1, 0, rd, er, lat, bo, so, ra);
         checks++; if (rd !== ed || er !== 1'b0) $display("FAIL mid_rst_data k=%0d: got %h expected %h", k, rd, ed); else passes++;
      end
   endtask

   task automatic test_random();
      logic [BW-1:0] wd, rd, ed; logic er, ee, bo, so, ra, we; logic [PA-1:0] addr;
      logic [NB-1:0] be; int lat, stall;
      for (int n = 0; n < 40; n++) begin
         we = 1'($urandom());
         addr = ($urandom_range(0, 3) == 0) ? ($urandom() | 32'h400) : PA'($urandom_range(0, DEP * NB - 1));
         wd = rand_blk();
`ifdef BLK_MEM_BYTE_EN
         be = {$urandom(), $urandom()};
`else
         be = '1;
`endif
         stall = $urandom_range(0, 3);
         model_access(we, addr, wd, be, ed, ee);
         do_req(we, addr, wd, be, stall, rd, er, lat, bo, so, ra);
         checks++; if (lat !== LAT) $display("FAIL rnd_lat n=%0d: got %0d expected %0d", n, lat, LAT); else passes++;
         checks++; if (rd !== ed || er !== ee) $display("FAIL rnd_resp n=%0d: got %h/%b expected %h/%b", n, rd, er, ed, ee); else passes++;
         checks++; if (bo !== 1'b1 || so !== 1'b1 || ra !== 1'b1)
            $display("FAIL rnd_hs n=%0d: got busy=%b stable=%b ready=%b expected 1/1/1", n, bo, so, ra);
         else passes++;
      end
   endtask

`ifdef BLK_MEM_BYTE_EN
   task automatic test_byte_en();
      logic [BW-1:0] rd, ed, exp1; logic er, ee, bo, so, ra; int lat;
      exp1 = {BW{1'b1}};
      exp1[7:0] = 8'h00;
      model_access(1'b1, 32'h0, '1, '1, ed, ee);
      do_req(1'b1, 32'h0, '1, '1, 0, rd, er, lat, bo, so, ra);
      model_access(1'b1, 32'h0, '0, NB'(1), ed, ee);
      do_req(1'b1, 32'h0, '0, NB'(1), 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== exp1) $display("FAIL be_wr_resp: got %h expected %h", rd, exp1); else passes++;
      do_req(1'b0, 32'h0, '0, '0, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== exp1) $display("FAIL be_rd: got %h expected %h", rd, exp1); else passes++;
      model_access(1'b1, 32'h0, '0, '0, ed, ee);
      do_req(1'b1, 32'h0, '0, '0, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== exp1 || lat !== LAT) $display("FAIL be_zero: got %h lat %0d expected %h lat %0d", rd, lat, exp1, LAT); else passes++;
      do_req(1'b0, 32'h0, '0, '1, 0, rd, er, lat, bo, so, ra);
      checks++; if (rd !== exp1) $display("FAIL be_zero_rd: got %h expected %h", rd, exp1); else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_write_read();
      test_backpressure();
      test_range();
      test_reset_mid();
`ifdef BLK_MEM_BYTE_EN
      test_byte_en();
`endif
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
